// File: rtl/cache_pkg.sv
// Shared geometry, refill state encoding and address helpers for the
// direct-mapped data cache and its refill controller.
package cache_pkg;

  localparam int BLOCK_SIZE             = 32;
  localparam int NUM_OF_BLOCKS_PER_LINE = 4;
  localparam int NUM_OF_CACHE_LINES     = 4;
  localparam int ADDRESS_SIZE           = 32;

  localparam int OFFSET_LENGTH = $clog2(NUM_OF_BLOCKS_PER_LINE);
  localparam int INDEX_LENGTH  = $clog2(NUM_OF_CACHE_LINES);
  localparam int TAG_LENGTH    = ADDRESS_SIZE - OFFSET_LENGTH - INDEX_LENGTH;
  localparam int LINE_BITS     = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

  typedef logic [ADDRESS_SIZE-1:0]  addr_t;
  typedef logic [TAG_LENGTH-1:0]    tag_t;
  typedef logic [INDEX_LENGTH-1:0]  index_t;
  typedef logic [OFFSET_LENGTH-1:0] offset_t;
  typedef logic [BLOCK_SIZE-1:0]    block_t;
  typedef logic [LINE_BITS-1:0]     line_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_COMMIT  = 3'd4
  } refill_state_e;

  function automatic tag_t tag_of(input addr_t a);
    return tag_t'(a >> (OFFSET_LENGTH + INDEX_LENGTH));
  endfunction

  function automatic index_t index_of(input addr_t a);
    return index_t'(a >> OFFSET_LENGTH);
  endfunction

  function automatic addr_t block_addr(input tag_t t, input index_t i, input offset_t o);
    return {t, i, o};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Block-addressed memory bus between the refill controller (master) and
// backing memory (slave): one request channel plus a read-data return.
interface cache_refill_ctrl_if
  import cache_pkg::*;
();
  logic   mem_valid;
  logic   mem_ready;
  logic   mem_write;
  addr_t  mem_addr;
  block_t mem_wdata;
  logic   mem_rvalid;
  block_t mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_line_buffer.sv
// One cache line of storage: whole-line load for the victim, per-block write
// for returning read beats, and a per-block read mux for write-back beats.
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load_en,
  input  line_t   load_line,
  input  logic    wr_en,
  input  offset_t wr_idx,
  input  block_t  wr_data,
  input  offset_t rd_idx,
  output block_t  rd_data,
  output line_t   line
);
  logic [NUM_OF_BLOCKS_PER_LINE-1:0][BLOCK_SIZE-1:0] blk_r;

  // Line storage; a load takes priority over a single-block write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_r <= '0;
    end else if (load_en) begin
      blk_r <= load_line;
    end else if (wr_en) begin
      blk_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = blk_r[rd_idx];
  assign line    = blk_r;
endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss handler for the direct-mapped cache: optional dirty-victim write-back,
// beat-by-beat line fetch, then a single-cycle fill of the assembled line.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   miss_valid,
  output logic   miss_ready,
  input  addr_t  miss_addr,
  input  logic   victim_valid,
  input  logic   victim_dirty,
  input  tag_t   victim_tag,
  input  line_t  victim_line,
  output logic   fill_valid,
  output index_t fill_index,
  output tag_t   fill_tag,
  output line_t  fill_line,
  output logic   busy,
  cache_refill_ctrl_if.master mem
);
  localparam offset_t LAST_BEAT = offset_t'(NUM_OF_BLOCKS_PER_LINE - 1);
  localparam offset_t BEAT_ONE  = offset_t'(1);

  refill_state_e state_r, state_nx_s;
  offset_t beat_r, beat_nx_s;
  tag_t    miss_tag_r, miss_tag_nx_s, victim_tag_r, victim_tag_nx_s;
  index_t  index_r, index_nx_s;
  logic    buf_load_s, buf_wr_s;
  block_t  buf_rd_s;
  line_t   buf_line_s;
  logic    mem_valid_r, mem_write_r, busy_r, fill_valid_r;
  addr_t   mem_addr_r, mem_addr_nx_s;
  block_t  mem_wdata_r, mem_wdata_nx_s;
  index_t  fill_index_r;
  tag_t    fill_tag_r;
  line_t   fill_line_r;
  logic [NUM_OF_BLOCKS_PER_LINE-1:0][BLOCK_SIZE-1:0] fill_blk_s;

  cache_line_buffer u_line_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (buf_load_s),
    .load_line (victim_line),
    .wr_en     (buf_wr_s),
    .wr_idx    (beat_r),
    .wr_data   (mem.mem_rdata),
    .rd_idx    (beat_nx_s),
    .rd_data   (buf_rd_s),
    .line      (buf_line_s)
  );

  // Next-state, beat and capture logic; the buffer is shared by victim and fill.
  always_comb begin
    state_nx_s      = state_r;
    beat_nx_s       = beat_r;
    miss_tag_nx_s   = miss_tag_r;
    victim_tag_nx_s = victim_tag_r;
    index_nx_s      = index_r;
    buf_load_s      = 1'b0;
    buf_wr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (miss_valid) begin
          buf_load_s      = 1'b1;
          miss_tag_nx_s   = tag_of(miss_addr);
          index_nx_s      = index_of(miss_addr);
          victim_tag_nx_s = victim_tag;
          beat_nx_s       = '0;
          if (victim_valid && victim_dirty) begin
            state_nx_s = ST_WB;
          end else begin
            state_nx_s = ST_RD_REQ;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WB: begin
        if (mem.mem_ready) begin
          beat_nx_s = beat_r + BEAT_ONE;
          if (beat_r == LAST_BEAT) begin
            state_nx_s = ST_RD_REQ;
          end else begin
            state_nx_s = ST_WB;
          end
        end else begin
          state_nx_s = ST_WB;
        end
      end
      ST_RD_REQ: begin
        if (mem.mem_ready) begin
          state_nx_s = ST_RD_WAIT;
        end else begin
          state_nx_s = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (mem.mem_rvalid) begin
          buf_wr_s  = 1'b1;
          beat_nx_s = beat_r + BEAT_ONE;
          if (beat_r == LAST_BEAT) begin
            state_nx_s = ST_COMMIT;
          end else begin
            state_nx_s = ST_RD_REQ;
          end
        end else begin
          state_nx_s = ST_RD_WAIT;
        end
      end
      ST_COMMIT: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state, so they hold through stalls.
  always_comb begin
    mem_addr_nx_s  = '0;
    mem_wdata_nx_s = '0;
    fill_blk_s     = buf_line_s;
    fill_blk_s[LAST_BEAT] = mem.mem_rdata;
    if (state_nx_s == ST_WB) begin
      mem_addr_nx_s  = block_addr(victim_tag_nx_s, index_nx_s, beat_nx_s);
      mem_wdata_nx_s = buf_load_s ? victim_line[BLOCK_SIZE-1:0] : buf_rd_s;
    end else if (state_nx_s == ST_RD_REQ) begin
      mem_addr_nx_s  = block_addr(miss_tag_nx_s, index_nx_s, beat_nx_s);
    end else begin
      mem_addr_nx_s  = '0;
    end
  end

  // State, captured miss fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      beat_r       <= '0;
      miss_tag_r   <= '0;
      victim_tag_r <= '0;
      index_r      <= '0;
      busy_r       <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      fill_valid_r <= 1'b0;
      fill_index_r <= '0;
      fill_tag_r   <= '0;
      fill_line_r  <= '0;
    end else begin
      state_r      <= state_nx_s;
      beat_r       <= beat_nx_s;
      miss_tag_r   <= miss_tag_nx_s;
      victim_tag_r <= victim_tag_nx_s;
      index_r      <= index_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      mem_valid_r  <= (state_nx_s == ST_WB) || (state_nx_s == ST_RD_REQ);
      mem_write_r  <= (state_nx_s == ST_WB);
      mem_addr_r   <= mem_addr_nx_s;
      mem_wdata_r  <= mem_wdata_nx_s;
      fill_valid_r <= (state_nx_s == ST_COMMIT);
      if (state_nx_s == ST_COMMIT) begin
        fill_index_r <= index_r;
        fill_tag_r   <= miss_tag_r;
        fill_line_r  <= fill_blk_s;
      end
    end
  end

  assign miss_ready    = !busy_r;
  assign busy          = busy_r;
  assign fill_valid    = fill_valid_r;
  assign fill_index    = fill_index_r;
  assign fill_tag      = fill_tag_r;
  assign fill_line     = fill_line_r;
  assign mem.mem_valid = mem_valid_r;
  assign mem.mem_write = mem_write_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed, table-driven bench for cache_refill_ctrl with a small memory
// responder model and hand-written reset / held-miss sequences.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic   clk;
  logic   rst_n;
  logic   miss_valid;
  logic   miss_ready;
  addr_t  miss_addr;
  logic   victim_valid;
  logic   victim_dirty;
  tag_t   victim_tag;
  line_t  victim_line;
  logic   fill_valid;
  index_t fill_index;
  tag_t   fill_tag;
  line_t  fill_line;
  logic   busy;

  cache_refill_ctrl_if mem_if ();

  cache_refill_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miss_valid   (miss_valid),
    .miss_ready   (miss_ready),
    .miss_addr    (miss_addr),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_line  (victim_line),
    .fill_valid   (fill_valid),
    .fill_index   (fill_index),
    .fill_tag     (fill_tag),
    .fill_line    (fill_line),
    .busy         (busy),
    .mem          (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic         vvalid;
    logic         vdirty;
    logic [27:0]  vtag;
    logic [127:0] vline;
    logic [31:0]  rbase;
    int           stall;
    logic         spur;
    logic         hold;
    int           exp_cyc;
    logic [1:0]   exp_idx;
    logic [27:0]  exp_tag;
    int           exp_nwr;
    logic [31:0]  exp_wr;
    logic [31:0]  exp_rd;
    logic [127:0] exp_line;
  } vec_t;

  int   checks;
  int   fails;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_write;
    logic [31:0] pend_data;
    logic        pend;
    logic        hs;
    logic        hs_write;
    logic [31:0] hs_addr;
    logic [31:0] hs_wdata;
    int          cyc;
    int          fills;
    int          nwr;
    int          nrd;
    int          stall_cnt;
    l_addr = '0; l_wdata = '0; l_write = 1'b0; pend = 1'b0; pend_data = '0;
    fills = 0; nwr = 0; nrd = 0; stall_cnt = 0;
    if (v.spur) begin
      @(negedge clk);
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      chk("idle_spur_busy", 128'(busy), 128'(1'b0));
      chk("idle_spur_fill", 128'(fill_valid), 128'(1'b0));
    end
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_ready  = 1'b0;
    miss_valid   = 1'b1;
    miss_addr    = v.addr;
    victim_valid = v.vvalid;
    victim_dirty = v.vdirty;
    victim_tag   = v.vtag;
    victim_line  = v.vline;
    chk("ready_idle", 128'(miss_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    miss_valid = v.hold;
    if (!v.hold) begin
      victim_tag  = '1;
      victim_line = '1;
      miss_addr   = '1;
    end
    cyc = 1;
    while (cyc <= 200 && fills == 0) begin
      @(negedge clk);
      chk("busy_during", 128'(busy), 128'(1'b1));
      chk("ready_during", 128'(miss_ready), 128'(1'b0));
      if (fill_valid) begin
        fills++;
        chk("fill_cycle", 128'(cyc), 128'(v.exp_cyc));
        chk("fill_index", 128'(fill_index), 128'(v.exp_idx));
        chk("fill_tag", 128'(fill_tag), 128'(v.exp_tag));
        chk("fill_line", fill_line, v.exp_line);
      end
      if (stall_cnt > 0) begin
        chk("stall_valid", 128'(mem_if.mem_valid), 128'(1'b1));
        chk("stall_addr", 128'(mem_if.mem_addr), 128'(l_addr));
        chk("stall_wdata", 128'(mem_if.mem_wdata), 128'(l_wdata));
        chk("stall_write", 128'(mem_if.mem_write), 128'(l_write));
      end else begin
        l_addr  = mem_if.mem_addr;
        l_wdata = mem_if.mem_wdata;
        l_write = mem_if.mem_write;
      end
      mem_if.mem_rvalid = pend;
      mem_if.mem_rdata  = pend_data;
      if (!pend && v.spur && mem_if.mem_valid && !mem_if.mem_write) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hDEAD_BEEF;
      end
      mem_if.mem_ready = mem_if.mem_valid && (stall_cnt >= v.stall);
      hs       = mem_if.mem_valid && mem_if.mem_ready;
      hs_write = mem_if.mem_write;
      hs_addr  = mem_if.mem_addr;
      hs_wdata = mem_if.mem_wdata;
      @(posedge clk);
      pend = 1'b0;
      if (hs) begin
        stall_cnt = 0;
        if (hs_write) begin
          chk("wr_addr", 128'(hs_addr), 128'(v.exp_wr + 32'(nwr)));
          chk("wr_data", 128'(hs_wdata), 128'(v.vline[nwr*32 +: 32]));
          nwr++;
        end else begin
          chk("rd_addr", 128'(hs_addr), 128'(v.exp_rd + 32'(nrd)));
          chk("wr_before_rd", 128'(nwr), 128'(v.exp_nwr));
          pend      = 1'b1;
          pend_data = v.rbase + 32'(nrd);
          nrd++;
        end
      end else if (mem_if.mem_valid) begin
        stall_cnt++;
      end
      cyc++;
    end
    if (fills == 0) chk("fill_timeout", 128'(1'b0), 128'(1'b1));
    chk("n_writes", 128'(nwr), 128'(v.exp_nwr));
    chk("n_reads", 128'(nrd), 128'(4));
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_ready  = 1'b0;
    @(negedge clk);
    chk("fill_pulse_end", 128'(fill_valid), 128'(1'b0));
    chk("ready_after", 128'(miss_ready), 128'(1'b1));
    chk("fill_tag_hold", 128'(fill_tag), 128'(v.exp_tag));
    chk("fill_line_hold", fill_line, v.exp_line);
    if (v.hold) begin
      // The held request is taken on this edge; abandon it with a reset.
      @(posedge clk);
      #1;
      chk("held_accept_busy", 128'(busy), 128'(1'b1));
      chk("held_accept_ready", 128'(miss_ready), 128'(1'b0));
      miss_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("held_reset_busy", 128'(busy), 128'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk("idle_busy", 128'(busy), 128'(1'b0));
      chk("idle_mem_valid", 128'(mem_if.mem_valid), 128'(1'b0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fill_valid"}, 128'(fill_valid), 128'(1'b0));
    chk({tag, "_busy"}, 128'(busy), 128'(1'b0));
    chk({tag, "_ready"}, 128'(miss_ready), 128'(1'b1));
    chk({tag, "_mem_valid"}, 128'(mem_if.mem_valid), 128'(1'b0));
    chk({tag, "_mem_write"}, 128'(mem_if.mem_write), 128'(1'b0));
    chk({tag, "_mem_addr"}, 128'(mem_if.mem_addr), 128'(32'h0));
    chk({tag, "_mem_wdata"}, 128'(mem_if.mem_wdata), 128'(32'h0));
    chk({tag, "_fill_index"}, 128'(fill_index), 128'(2'd0));
    chk({tag, "_fill_tag"}, 128'(fill_tag), 128'(28'd0));
    chk({tag, "_fill_line"}, fill_line, 128'd0);
  endtask

  initial begin
    logic pend;
    int   nfill;
    checks = 0;
    fails  = 0;
    //          addr          vv    vd    vtag         vline                                        rbase        st pend hold cyc idx   tag             nwr wr_base      rd_base      line
    vecs[0] = '{32'h0000_0016, 1'b0, 1'b0, 28'h0,       128'h0,                                      32'hA0,      0, 1'b0, 1'b0, 9,  2'd1, 28'h1,          0, 32'h0,       32'h14,      128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{32'h0000_0039, 1'b1, 1'b1, 28'h5,       128'h000000D3_000000D2_000000D1_000000D0,    32'hB0,      0, 1'b0, 1'b0, 13, 2'd2, 28'h3,          4, 32'h58,      32'h38,      128'h000000B3_000000B2_000000B1_000000B0};
    vecs[2] = '{32'hFFFF_FFFE, 1'b1, 1'b0, 28'h1234567, 128'h01234567_89ABCDEF_FEDCBA98_76543210,    32'hC0,      0, 1'b0, 1'b0, 9,  2'd3, 28'hFFF_FFFF,    0, 32'h0,       32'hFFFF_FFFC, 128'h000000C3_000000C2_000000C1_000000C0};
    vecs[3] = '{32'h0000_0025, 1'b0, 1'b1, 28'h7,       128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,    32'hE0,      0, 1'b0, 1'b0, 9,  2'd1, 28'h2,          0, 32'h0,       32'h24,      128'h000000E3_000000E2_000000E1_000000E0};
    vecs[4] = '{32'h0000_004C, 1'b1, 1'b1, 28'h6,       128'h00000044_00000033_00000022_00000011,    32'hF0,      3, 1'b0, 1'b0, 37, 2'd3, 28'h4,          4, 32'h6C,      32'h4C,      128'h000000F3_000000F2_000000F1_000000F0};
    vecs[5] = '{32'h0000_0016, 1'b0, 1'b0, 28'h0,       128'h0,                                      32'h10,      3, 1'b1, 1'b0, 21, 2'd1, 28'h1,          0, 32'h0,       32'h14,      128'h00000013_00000012_00000011_00000010};
    vecs[6] = '{32'h0000_0008, 1'b0, 1'b0, 28'h0,       128'h0,                                      32'h50,      0, 1'b0, 1'b1, 9,  2'd2, 28'h0,          0, 32'h0,       32'h08,      128'h00000053_00000052_00000051_00000050};

    rst_n = 1'b0;
    miss_valid = 1'b0; miss_addr = '0; victim_valid = 1'b0; victim_dirty = 1'b0;
    victim_tag = '0; victim_line = '0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while waiting for read beat 2: no fill, everything returns to zero.
    @(negedge clk);
    miss_valid = 1'b1; miss_addr = 32'h0000_0016; victim_valid = 1'b0; victim_dirty = 1'b0;
    @(posedge clk);
    #1;
    miss_valid = 1'b0;
    pend = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_if.mem_ready  = 1'b1;
      mem_if.mem_rvalid = pend;
      mem_if.mem_rdata  = 32'h77;
      pend = mem_if.mem_valid && !mem_if.mem_write;
      @(posedge clk);
    end
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_ready  = 1'b0;
    chk("rdwait_busy", 128'(busy), 128'(1'b1));
    chk("rdwait_mem_valid", 128'(mem_if.mem_valid), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    nfill = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mem_if.mem_rvalid = 1'b1;
      if (fill_valid || busy) nfill++;
    end
    mem_if.mem_rvalid = 1'b0;
    chk("post_reset_quiet", 128'(nfill), 128'(0));
    run_vec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-side partner of the direct-mapped data cache. It accepts a miss from the cache and writes back the victim line if it is dirty.
- It then fetches the missing line from backing memory one block per beat and returns the assembled line to the cache in a single fill pulse.
- It is the responder to the cache's hit/miss outputs and the initiator on the memory bus.

Parameters:
- BLOCK_SIZE, 32, bits per block (one memory beat).
- NUM_OF_BLOCKS_PER_LINE, 4, blocks per cache line (N); power of two, at least 2.
- NUM_OF_CACHE_LINES, 4, lines in cache; power of two.
- ADDRESS_SIZE, 32, address width; block-addressed, format {tag, index, block_offset}.
- Derived (localparam): OFFSET_LENGTH = clog2(N); INDEX_LENGTH = clog2(lines); TAG_LENGTH = ADDRESS_SIZE - OFFSET_LENGTH - INDEX_LENGTH; LINE_BITS = N*BLOCK_SIZE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- miss_valid  in  1  cache requests a refill.
- miss_ready  out  1  high only in IDLE; a miss is accepted when miss_valid and miss_ready are both high.
- miss_addr  in  ADDRESS_SIZE  address that missed.
- victim_valid  in  1  current line at the index is valid.
- victim_dirty  in  1  current line at the index is dirty.
- victim_tag  in  TAG_LENGTH  tag of the current line.
- victim_line  in  LINE_BITS  data of the current line; block k occupies bits [k*BLOCK_SIZE +: BLOCK_SIZE].
- fill_valid  out  1  one-cycle pulse; fill_index, fill_tag and fill_line are valid.
- fill_index  out  INDEX_LENGTH  line to overwrite.
- fill_tag  out  TAG_LENGTH  new tag; the cache sets valid=1, dirty=0.
- fill_line  out  LINE_BITS  refilled data, same packing as victim_line.
- busy  out  1  high in every state except IDLE.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts the request; a transfer occurs when mem_valid and mem_ready are both high.
- mem_write  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDRESS_SIZE  block address of the beat.
- mem_wdata  out  BLOCK_SIZE  write-beat data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  BLOCK_SIZE  read data.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; beat counter = 0; line buffer = 0.
  - fill_valid, busy, mem_valid, mem_write = 0; mem_addr, mem_wdata, fill_* = 0.
  - Reset mid-operation abandons the transfer: no fill pulse, partial data discarded.
- States: IDLE, WB, RD_REQ, RD_WAIT, COMMIT.
- IDLE:
  - miss_ready = 1.
  - On acceptance, capture the tag and index of miss_addr plus victim_tag and victim_line; beat = 0.
  - If victim_valid and victim_dirty, go to WB; otherwise go to RD_REQ. The block_offset of miss_addr is ignored.
- WB:
  - mem_valid=1, mem_write=1, mem_addr={victim_tag, index, beat}, mem_wdata = captured victim block[beat].
  - On handshake: beat+1. After beat N-1, go to RD_REQ with beat = 0.
- RD_REQ:
  - mem_valid=1, mem_write=0, mem_addr={miss_tag, index, beat}.
  - On handshake, go to RD_WAIT.
- RD_WAIT:
  - mem_valid=0.
  - On mem_rvalid: store mem_rdata into buffer block[beat]. If beat == N-1, go to COMMIT; otherwise beat+1 and go to RD_REQ.
- COMMIT:
  - fill_valid=1 for exactly one cycle, with fill_index, fill_tag and fill_line from the buffer; then go to IDLE.
  - fill_* hold their values until the next COMMIT.
- Handshake rules:
  - Once mem_valid is asserted, it and mem_addr, mem_write and mem_wdata stay stable until mem_ready.
  - At most one read outstanding at a time.
  - mem_rvalid is ignored outside RD_WAIT; an rvalid in the same cycle as the read handshake is ignored.
- Stall behaviour: mem_ready held low stalls indefinitely; no timeout.
- Beat counter: OFFSET_LENGTH bits, wraps to 0 after N-1.
- Simultaneous events: miss_valid while busy is not accepted (miss_ready=0); the cache must hold the request.
- Latency, default N=4, mem_ready tied high, rvalid one cycle after the read handshake:
  - Clean miss: fill_valid high in cycle 2N+1 = 9 after the acceptance edge.
  - Dirty miss: N more cycles, so cycle 13.

Decomposition:
- Package cache_pkg holds:
  - cache geometry parameters and the derived localparams (OFFSET_LENGTH, INDEX_LENGTH, TAG_LENGTH, LINE_BITS);
  - the refill state encoding;
  - address field-extraction functions (tag_of, index_of, block_addr).
  - The cache itself will use the same package.
- One sub-module, cache_line_buffer: an N x BLOCK_SIZE register with a write-block-by-index port and a read-block-by-index mux, used to capture the victim line and assemble the fill line.

Test Plan:
- Clean miss: victim_valid=0, miss_addr=0x0000_0016 (tag 1, index 1, offset 2), mem returns 0xA0..0xA3.
  -> Reads at addresses 0x14..0x17; fill_valid in cycle 9 with fill_index=1, fill_tag=1, fill_line={A3,A2,A1,A0}; no write beats.
- Dirty miss: victim_dirty=1, victim_tag=5, index 2, victim_line={D3,D2,D1,D0}.
  -> Write beats at 0x58..0x5B carrying D0..D3, then 4 reads; fill in cycle 13.
- Backpressure: mem_ready low for 3 cycles on each beat.
  -> mem_addr and mem_wdata stable throughout each stall; the line is still correct.
- Spurious rvalid in RD_REQ and in IDLE.
  -> Ignored; buffer unchanged; no extra fill.
- rst_n pulsed low during RD_WAIT of beat 2.
  -> All outputs 0 immediately; no fill_valid; the next miss completes normally.
- miss_valid held high through a refill.
  -> miss_ready=0 while busy; the second miss is accepted in the cycle after COMMIT.
